// File: rtl/poly_deci_ctrl.sv
// Sequencer and double-buffered coefficient manager for a polyphase decimator.
// Swaps the tap bank on an output boundary, then flushes the decimator and masks its warm-up outputs.
module poly_deci_ctrl #(
    parameter int RATE    = 4,
    parameter int TAP_LEN = 32,
    parameter int WARM    = (TAP_LEN + RATE - 1) / RATE,
    parameter int AW      = $clog2(TAP_LEN)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic [15:0]                      cke_period,
    output logic                             cke,
    output logic                             deci_rst,
    input  logic                             deci_cke_out,
    output logic                             valid_out,
    input  logic                             wr_en,
    input  logic [AW-1:0]                    wr_addr,
    input  logic signed [15:0]               wr_data,
    input  logic                             commit,
    output logic                             busy,
    output logic                             commit_done,
    output logic                             wr_drop,
    output logic signed [TAP_LEN-1:0][15:0]  tap
);

    localparam int WCW = $clog2(WARM + 1);

    typedef enum logic [1:0] {
        S_WARMUP  = 2'd0,
        S_RUN     = 2'd1,
        S_PENDING = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [1:0]     fcnt_q, fcnt_d;
    logic [15:0]    cnt_q;
    logic           cke_q;
    logic           done_q, done_d;
    logic           drop_q;
    logic           init_q;
    logic           swap;
    logic           accepting;
    logic           addr_ok;
    logic           wr_ok;

    assign accepting = (state_q == S_WARMUP) || (state_q == S_RUN);
    assign addr_ok   = ({1'b0, wr_addr} < (AW + 1)'(TAP_LEN));
    assign wr_ok     = wr_en && addr_ok && accepting;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        swap    = 1'b0;
        case (state_q)
            S_WARMUP: begin
                if (commit) begin
                    state_d = S_PENDING;
                end else if (deci_cke_out) begin
                    wcnt_d = wcnt_q - 1'b1;
                    if (wcnt_q == WCW'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (commit) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                // Stopping the sample stream also counts as a safe boundary.
                if (deci_cke_out || !run) begin
                    swap    = 1'b1;
                    state_d = S_FLUSH;
                    fcnt_d  = 2'd2;
                end
            end
            default: begin
                if (fcnt_q == 2'd1) begin
                    state_d = S_WARMUP;
                    wcnt_d  = WCW'(WARM);
                    done_d  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WARMUP;
            wcnt_q  <= WCW'(WARM);
            fcnt_q  <= 2'd0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
            drop_q  <= wr_en && !wr_ok;
            init_q  <= 1'b0;
        end
    end

    // Gating on the next state keeps cke low for every cycle spent in FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
            cke_q <= 1'b0;
        end else if (!run || state_d == S_FLUSH) begin
            cnt_q <= 16'd0;
            cke_q <= 1'b0;
        end else if (cnt_q == 16'd0) begin
            cnt_q <= cke_period;
            cke_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q - 16'd1;
            cke_q <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < TAP_LEN; gi++) begin : g_tap
        logic signed [15:0] shadow_q;
        logic signed [15:0] tap_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= '0;
                tap_q    <= '0;
            end else begin
                if (wr_ok && wr_addr == AW'(gi)) begin
                    shadow_q <= wr_data;
                end
                if (swap) begin
                    tap_q <= shadow_q;
                end
            end
        end

        assign tap[gi] = tap_q;
    end

    assign cke         = cke_q;
    assign deci_rst    = init_q || (state_q == S_FLUSH);
    assign valid_out   = (state_q == S_RUN) && deci_cke_out;
    assign busy        = (state_q == S_PENDING) || (state_q == S_FLUSH);
    assign commit_done = done_q;
    assign wr_drop     = drop_q;

endmodule

// File: tb/tb_poly_deci_ctrl.sv
// Self-checking bench for poly_deci_ctrl: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_poly_deci_ctrl;

    localparam int RATE    = 4;
    localparam int TAP_LEN = 32;
    localparam int WARM    = (TAP_LEN + RATE - 1) / RATE;
    localparam int AW      = 6;

    localparam int M_WARM  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PEND  = 2;
    localparam int M_FLUSH = 3;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            run;
    logic [15:0]                     cke_period;
    logic                            cke;
    logic                            deci_rst;
    logic                            deci_cke_out;
    logic                            valid_out;
    logic                            wr_en;
    logic [AW-1:0]                   wr_addr;
    logic signed [15:0]              wr_data;
    logic                            commit;
    logic                            busy;
    logic                            commit_done;
    logic                            wr_drop;
    logic signed [TAP_LEN-1:0][15:0] tap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_deci_ctrl #(
        .RATE    (RATE),
        .TAP_LEN (TAP_LEN),
        .AW      (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .cke_period   (cke_period),
        .cke          (cke),
        .deci_rst     (deci_rst),
        .deci_cke_out (deci_cke_out),
        .valid_out    (valid_out),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .busy         (busy),
        .commit_done  (commit_done),
        .wr_drop      (wr_drop),
        .tap          (tap)
    );

    // Behavioural model: mode, remaining warm-up outputs, remaining flush clocks,
    // and the index of the current clock within an uninterrupted run segment.
    int          m_mode;
    int          m_warm;
    int          m_flush;
    int          m_seg;
    logic        m_cke;
    logic        m_done;
    logic        m_drop;
    logic        m_first;
    logic [15:0] m_shadow [TAP_LEN];
    logic [15:0] m_tap    [TAP_LEN];

    bit chk_on   = 1'b0;
    bit dco_auto = 1'b0;
    int dco_ph   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_WARM;
        m_warm  = WARM;
        m_flush = 0;
        m_seg   = -1;
        m_cke   = 1'b0;
        m_done  = 1'b0;
        m_drop  = 1'b0;
        m_first = 1'b1;
        for (int i = 0; i < TAP_LEN; i++) begin
            m_shadow[i] = 16'h0000;
            m_tap[i]    = 16'h0000;
        end
    endtask

    task automatic model_edge();
        int nmode;
        nmode   = m_mode;
        m_first = 1'b0;
        m_drop  = 1'b0;
        m_done  = 1'b0;
        if (wr_en) begin
            if (m_mode == M_PEND || m_mode == M_FLUSH || int'(wr_addr) >= TAP_LEN)
                m_drop = 1'b1;
            else
                m_shadow[int'(wr_addr)] = wr_data;
        end
        case (m_mode)
            M_WARM: begin
                if (commit) nmode = M_PEND;
                else if (deci_cke_out) begin
                    m_warm--;
                    if (m_warm == 0) nmode = M_RUN;
                end
            end
            M_RUN: if (commit) nmode = M_PEND;
            M_PEND: begin
                if (deci_cke_out || !run) begin
                    for (int i = 0; i < TAP_LEN; i++) m_tap[i] = m_shadow[i];
                    nmode   = M_FLUSH;
                    m_flush = 2;
                end
            end
            default: begin
                m_flush--;
                if (m_flush == 0) begin
                    nmode  = M_WARM;
                    m_warm = WARM;
                    m_done = 1'b1;
                end
            end
        endcase
        if (!run || nmode == M_FLUSH) begin
            m_seg = -1;
            m_cke = 1'b0;
        end else begin
            m_seg++;
            m_cke = ((m_seg % (int'(cke_period) + 1)) == 0);
        end
        m_mode = nmode;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
        if (dco_auto) begin
            dco_ph       = (dco_ph + 1) % RATE;
            deci_cke_out = (dco_ph == RATE - 1);
        end else begin
            deci_cke_out = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            int bad;
            chk1("cke", cke, m_cke);
            chk1("deci_rst", deci_rst, m_first || (m_mode == M_FLUSH));
            chk1("valid_out", valid_out, (m_mode == M_RUN) && deci_cke_out);
            chk1("busy", busy, (m_mode == M_PEND) || (m_mode == M_FLUSH));
            chk1("commit_done", commit_done, m_done);
            chk1("wr_drop", wr_drop, m_drop);
            bad = -1;
            for (int i = 0; i < TAP_LEN; i++) if (tap[i] !== m_tap[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL tap[%0d]: got %h, want %h", bad, tap[bad], m_tap[bad]);
            end
        end
    end

    logic [7:0] hist;
    int pulses, first_valid, rstc, donec, busyc, done_at, ckc;
    logic [15:0] tap5_pre;

    initial begin
        rst = 1'b1; run = 1'b0; cke_period = 16'd3; deci_cke_out = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk1("reset_deci_rst", deci_rst, 1'b1);
        chk1("reset_cke", cke, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk16("reset_tap5", tap[5], 16'h0000);
        chk_on = 1'b1;

        // Sample enable, period 3: first pulse one clock after run, then every 4.
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            hist[i] = cke;
            if (i == 0) chk1("deci_rst_after_first_edge", deci_rst, 1'b0);
        end
        chk16("cke_pattern", {8'h00, hist}, 16'h0011);

        // Warm-up masking: 8 masked outputs, the 9th is valid.
        dco_auto = 1'b1; pulses = 0; first_valid = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); #1;
            if (deci_cke_out) begin
                pulses++;
                if (valid_out && first_valid == 0) first_valid = pulses;
            end
        end
        chk_int("first_valid_pulse", first_valid, WARM + 1);
        dco_auto = 1'b0;
        tick();

        // Write tap[5] and commit in RUN; swap waits for the next decimator output.
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'sh7FFF;
        tick(); #1;
        chk16("tap5_before_commit", tap[5], 16'h0000);
        commit = 1'b1;
        tick(); #1;
        chk1("busy_after_commit", busy, 1'b1);
        rstc = 0; donec = 0; busyc = 0; done_at = -1; tap5_pre = 16'hDEAD;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) deci_cke_out = 1'b1;
            tick(); #1;
            if (i == 2) tap5_pre = tap[5];
            if (deci_rst) rstc++;
            if (busy) busyc++;
            if (commit_done) begin donec++; done_at = i; end
        end
        chk16("tap5_while_pending", tap5_pre, 16'h0000);
        chk16("tap5_after_swap", tap[5], 16'h7FFF);
        chk_int("deci_rst_clocks", rstc, 2);
        chk_int("commit_done_count", donec, 1);
        chk_int("commit_done_at", done_at, 5);
        chk_int("busy_clocks", busyc, 5);

        // Rejected writes: during PENDING, during FLUSH, and out of range.
        commit = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'sh1234;
        tick(); #1;
        chk1("drop_in_pending", wr_drop, 1'b1);
        tick(); #1;
        chk1("drop_clears", wr_drop, 1'b0);
        deci_cke_out = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 6'd4; wr_data = 16'sh4444;
        tick(); #1;
        chk1("drop_in_flush", wr_drop, 1'b1);
        tick();
        wr_en = 1'b1; wr_addr = 6'd32; wr_data = 16'sh5555;
        tick(); #1;
        chk1("drop_addr_oob", wr_drop, 1'b1);
        commit = 1'b1;
        tick();
        deci_cke_out = 1'b1;
        tick(); #1;
        chk16("tap3_not_carried", tap[3], 16'h0000);
        chk16("tap4_not_carried", tap[4], 16'h0000);
        chk16("tap0_no_alias", tap[0], 16'h0000);
        chk16("tap5_kept", tap[5], 16'h7FFF);
        repeat (2) tick();

        // Write and commit together with run low: swap on the very next edge.
        run = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = -16'sd2; commit = 1'b1;
        tick(); #1;
        chk16("tap7_before_swap", tap[7], 16'h0000);
        tick(); #1;
        chk16("tap7_after_swap", tap[7], 16'hFFFE);
        chk1("flush_deci_rst", deci_rst, 1'b1);

        // Asynchronous reset in the middle of FLUSH.
        tick(); #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk16("arst_tap5", tap[5], 16'h0000);
        chk16("arst_tap7", tap[7], 16'h0000);
        chk1("arst_deci_rst", deci_rst, 1'b1);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_done", commit_done, 1'b0);
        chk1("arst_drop", wr_drop, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk1("deci_rst_held_after_release", deci_rst, 1'b1);

        // Period 0: cke every clock.
        cke_period = 16'd0; run = 1'b1; ckc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cke) ckc++;
        end
        chk_int("cke_period0_count", ckc, 4);
        dco_auto = 1'b1;
        repeat (40) tick();
        dco_auto = 1'b0;
        tick();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
